overflow_range_store: RTL and testbench

OVERFLOW_RANGE_STORE -- requirements
Module: overflow_range_store

---
 rtl/overflow_range_store.sv | 105 ++++++++++
 tb/tb_overflow_range_store.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/overflow_range_store.sv
// Small ring of recorded overflow ranges with zero-latency lookups.
// Lookups flag whether an address, or a load run, touches a recorded range.
module overflow_range_store #(
    parameter int DEPTH = 8
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       rst_us,
    input  logic                       en_write_i,
    input  logic [31:0]                addr_first_i,
    input  logic [31:0]                addr_last_i,
    input  logic [31:0]                find_addr_i,
    output logic                       addr_in_range_o,
    input  logic [31:0]                base_addr_i,
    output logic                       read_overflow_o,
    output logic [31:0]                read_o,
    output logic [31:0]                read2_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic                       full_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [31:0]      first_q [DEPTH];
    logic [31:0]      first_d [DEPTH];
    logic [31:0]      last_q  [DEPTH];
    logic [31:0]      last_d  [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW-1:0]    wp_q, wp_d;
    logic [CW-1:0]    count_q, count_d;

    logic [AW-1:0]    newest_idx;
    logic             ordered;
    logic             dup;
    logic             write_ok;
    logic [DEPTH-1:0] hit_vec;
    logic [DEPTH-1:0] ovf_vec;

    // wp wraps naturally because DEPTH is a power of two
    assign newest_idx = wp_q - AW'(1);
    assign ordered    = (addr_first_i <= addr_last_i);
    assign dup        = (count_q != '0) && valid_q[newest_idx]
                        && (first_q[newest_idx] == addr_first_i)
                        && (last_q[newest_idx] == addr_last_i);
    assign write_ok   = en_write_i && ordered && !dup;

    always_comb begin
        first_d = first_q;
        last_d  = last_q;
        valid_d = valid_q;
        wp_d    = wp_q;
        count_d = count_q;
        if (rst_us) begin
            // Soft clear leaves stored addresses in place; only bookkeeping resets
            valid_d = '0;
            wp_d    = '0;
            count_d = '0;
        end else if (write_ok) begin
            first_d[wp_q] = addr_first_i;
            last_d[wp_q]  = addr_last_i;
            valid_d[wp_q] = 1'b1;
            wp_d          = wp_q + AW'(1);
            if (count_q != FULL_CNT) begin
                count_d = count_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_q <= '{default: '0};
            last_q  <= '{default: '0};
            valid_q <= '0;
            wp_q    <= '0;
            count_q <= '0;
        end else begin
            first_q <= first_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            wp_q    <= wp_d;
            count_q <= count_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign hit_vec[gi] = valid_q[gi]
                             && (first_q[gi] <= find_addr_i)
                             && (find_addr_i <= last_q[gi]);
        // Run began inside this range and the current access has walked past its end
        assign ovf_vec[gi] = valid_q[gi]
                             && (first_q[gi] <= base_addr_i)
                             && (base_addr_i <= last_q[gi])
                             && (find_addr_i > last_q[gi]);
    end

    assign addr_in_range_o = |hit_vec;
    assign read_overflow_o = |ovf_vec;
    assign read_o          = (count_q == '0) ? 32'h0 : first_q[newest_idx];
    assign read2_o         = (count_q == '0) ? 32'h0 : last_q[newest_idx];
    assign count_o         = count_q;
    assign full_o          = (count_q == FULL_CNT);

endmodule

// File: tb/tb_overflow_range_store.sv
// Directed and randomized checks of overflow_range_store against a queue-based model.
module tb_overflow_range_store;

    localparam int DEPTH = 8;
    localparam int CW = $clog2(DEPTH) + 1;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          rst_us;
    logic          en_write_i;
    logic [31:0]   addr_first_i;
    logic [31:0]   addr_last_i;
    logic [31:0]   find_addr_i;
    logic          addr_in_range_o;
    logic [31:0]   base_addr_i;
    logic          read_overflow_o;
    logic [31:0]   read_o;
    logic [31:0]   read2_o;
    logic [CW-1:0] count_o;
    logic          full_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] f;
        logic [31:0] l;
    } rng_t;

    // Model: list of live ranges, oldest first, at most DEPTH long
    rng_t mq[$];

    overflow_range_store #(.DEPTH(DEPTH)) dut (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .rst_us          (rst_us),
        .en_write_i      (en_write_i),
        .addr_first_i    (addr_first_i),
        .addr_last_i     (addr_last_i),
        .find_addr_i     (find_addr_i),
        .addr_in_range_o (addr_in_range_o),
        .base_addr_i     (base_addr_i),
        .read_overflow_o (read_overflow_o),
        .read_o          (read_o),
        .read2_o         (read2_o),
        .count_o         (count_o),
        .full_o          (full_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic m_hit(input logic [31:0] a);
        foreach (mq[i]) if (mq[i].f <= a && a <= mq[i].l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_ovf(input logic [31:0] b, input logic [31:0] a);
        foreach (mq[i]) if (mq[i].f <= b && b <= mq[i].l && a > mq[i].l) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_rd_first();
        return (mq.size() == 0) ? 32'h0 : mq[mq.size()-1].f;
    endfunction

    function automatic logic [31:0] m_rd_last();
        return (mq.size() == 0) ? 32'h0 : mq[mq.size()-1].l;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_inr"},   32'(addr_in_range_o), 32'(m_hit(find_addr_i)));
        chk({tag, "_ovf"},   32'(read_overflow_o), 32'(m_ovf(base_addr_i, find_addr_i)));
        chk({tag, "_cnt"},   32'(count_o),         32'(mq.size()));
        chk({tag, "_full"},  32'(full_o),          32'(mq.size() == DEPTH));
        chk({tag, "_rd"},    read_o,               m_rd_first());
        chk({tag, "_rd2"},   read2_o,              m_rd_last());
    endtask

    // Called at posedge+1; returns at the following posedge+1
    task automatic step(input string tag, input bit we, input logic [31:0] f,
                        input logic [31:0] l, input logic [31:0] fa,
                        input logic [31:0] ba, input bit us);
        en_write_i   = we;
        addr_first_i = f;
        addr_last_i  = l;
        find_addr_i  = fa;
        base_addr_i  = ba;
        rst_us       = us;
        #1;
        chk_model(tag);
        $display("step %s we=%0d f=%h l=%h find=%h base=%h us=%0d inr=%0d ovf=%0d cnt=%0d",
                 tag, we, f, l, fa, ba, us, addr_in_range_o, read_overflow_o, count_o);
        @(posedge clk_i);
        if (us) begin
            mq.delete();
        end else if (we && f <= l &&
                     !(mq.size() > 0 && mq[mq.size()-1].f == f && mq[mq.size()-1].l == l)) begin
            mq.push_back('{f: f, l: l});
            if (mq.size() > DEPTH) void'(mq.pop_front());
        end
        #1;
        en_write_i = 1'b0;
        rst_us     = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [31:0] f, input logic [31:0] l);
        step(tag, 1'b1, f, l, 32'h0, 32'h0, 1'b0);
    endtask

    // Lookup-only probe with constant expectations as well as the model
    task automatic probe(input string tag, input logic [31:0] fa, input logic [31:0] ba,
                         input logic exp_inr, input logic exp_ovf);
        find_addr_i = fa;
        base_addr_i = ba;
        #1;
        chk({tag, "_inr_k"}, 32'(addr_in_range_o), 32'(exp_inr));
        chk({tag, "_ovf_k"}, 32'(read_overflow_o), 32'(exp_ovf));
        chk_model(tag);
        $display("probe %s find=%h base=%h inr=%0d ovf=%0d", tag, fa, ba,
                 addr_in_range_o, read_overflow_o);
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_inr0"},  32'(addr_in_range_o), 32'h0);
        chk({tag, "_ovf0"},  32'(read_overflow_o), 32'h0);
        chk({tag, "_rd0"},   read_o,               32'h0);
        chk({tag, "_rd20"},  read2_o,              32'h0);
        chk({tag, "_cnt0"},  32'(count_o),         32'h0);
        chk({tag, "_full0"}, 32'(full_o),          32'h0);
    endtask

    task automatic rand_steps(input string tag, input int n);
        logic [31:0] f, l, lf, ll;
        bit we, us;
        lf = 32'h4000;
        ll = 32'h4010;
        for (int i = 0; i < n; i++) begin
            we = ($urandom_range(0, 1) == 1);
            us = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 3) == 0) begin
                f = lf;
                l = ll;
            end else begin
                f = 32'h4000 + 32'($urandom_range(0, 15)) * 32'd16;
                l = f + 32'($urandom_range(0, 40)) - 32'd8;
            end
            if (we) begin
                lf = f;
                ll = l;
            end
            if ($urandom_range(0, 3) == 0 && mq.size() > 0) begin
                rng_t e;
                e = mq[$urandom_range(0, mq.size() - 1)];
                step(tag, we, f, l, e.l + 32'($urandom_range(0, 1)), e.f, us);
            end else begin
                step(tag, we, f, l, 32'h4000 + 32'($urandom_range(0, 300)),
                     32'h4000 + 32'($urandom_range(0, 300)), us);
            end
        end
    endtask

    initial begin
        rst_ni       = 1'b0;
        rst_us       = 1'b0;
        en_write_i   = 1'b0;
        addr_first_i = 32'h0;
        addr_last_i  = 32'h0;
        find_addr_i  = 32'h0;
        base_addr_i  = 32'h0;
        #2;
        chk_all_zero("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        chk_all_zero("post_reset");

        // Single range, boundary lookups
        wr("s31_wr", 32'h1000, 32'h1027);
        probe("s31_lo_m1", 32'h0FFF, 32'h0, 1'b0, 1'b0);
        probe("s31_lo",    32'h1000, 32'h0, 1'b1, 1'b0);
        probe("s31_hi",    32'h1027, 32'h0, 1'b1, 1'b0);
        probe("s31_hi_p1", 32'h1028, 32'h0, 1'b0, 1'b0);
        chk("s31_cnt",  32'(count_o), 32'd1);
        chk("s31_rd",   read_o,  32'h1000);
        chk("s31_rd2",  read2_o, 32'h1027);

        // Load-run overflow detection
        probe("s34_ovf",    32'h1028, 32'h1010, 1'b0, 1'b1);
        probe("s34_inside", 32'h1020, 32'h1010, 1'b1, 1'b0);
        probe("s34_base_out", 32'h1028, 32'h0FF0, 1'b0, 1'b0);

        // Inverted and duplicate writes are dropped
        step("s33_clr", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        wr("s33_inv",  32'h2000, 32'h1FFF);
        wr("s33_w1",   32'h1000, 32'h1027);
        wr("s33_dup",  32'h1000, 32'h1027);
        chk("s33_cnt", 32'(count_o), 32'd1);

        // Soft clear beats a simultaneous write
        wr("s35_w2", 32'h5000, 32'h50FF);
        wr("s35_w3", 32'h6000, 32'h60FF);
        chk("s35_cnt3", 32'(count_o), 32'd3);
        step("s35_clr_wr", 1'b1, 32'h7000, 32'h70FF, 32'h0, 32'h0, 1'b1);
        chk_all_zero("s35_after");
        probe("s35_look", 32'h7000, 32'h1000, 1'b0, 1'b0);

        // Nine ranges into eight slots: oldest evicted
        for (int i = 0; i < 9; i++) begin
            wr("s32_wr", 32'h10000 + 32'(i) * 32'h100, 32'h100FF + 32'(i) * 32'h100);
        end
        chk("s32_cnt",  32'(count_o), 32'd8);
        chk("s32_full", 32'(full_o),  32'd1);
        chk("s32_rd",   read_o, 32'h10800);
        probe("s32_r0", 32'h10000, 32'h0, 1'b0, 1'b0);
        probe("s32_r1", 32'h10150, 32'h0, 1'b1, 1'b0);
        probe("s32_r8", 32'h108FF, 32'h0, 1'b1, 1'b0);

        // Write visible only from the next cycle
        step("s36_clr", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1);
        step("s36_same", 1'b1, 32'h3000, 32'h3040, 32'h3010, 32'h0, 1'b0);
        probe("s36_next", 32'h3010, 32'h0, 1'b1, 1'b0);

        rand_steps("rnd_a", 250);

        // Asynchronous reset mid-run, with a write strobed at the same time
        en_write_i   = 1'b1;
        addr_first_i = 32'h8000;
        addr_last_i  = 32'h80FF;
        find_addr_i  = 32'h8000;
        #2;
        rst_ni = 1'b0;
        mq.delete();
        #1;
        chk_all_zero("s36_rst_now");
        @(posedge clk_i);
        #1;
        chk_all_zero("s36_rst_hold");
        en_write_i = 1'b0;
        rst_ni     = 1'b1;
        probe("s36_rst_after", 32'h8000, 32'h0, 1'b0, 1'b0);

        rand_steps("rnd_b", 250);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
